// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, retry counter width and per-state output decode
package pll_seq_pkg;
   typedef enum logic [2:0] {OFF, RESET, WAIT_LOCK, RUN, FAULT} state_t;
   localparam int RETRY_W = 2;
   typedef struct packed {
      logic pwd;
      logic prst;
      logic rst_out;
      logic locked;
      logic fault;
   } outs_t;
   function automatic outs_t decode(state_t s);
      outs_t o;
      o.pwd     = (s == OFF) || (s == FAULT);
      o.prst    = (s == OFF) || (s == RESET) || (s == FAULT);
      o.rst_out = s != RUN;
      o.locked  = s == RUN;
      o.fault   = s == FAULT;
      return o;
   endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-flop synchronizer for the raw PLL lock, async reset to 0
module pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic lock_i,
   output logic lock_s_o
);
   logic meta_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) {lock_s_o, meta_q} <= '0;
      else     {lock_s_o, meta_q} <= {meta_q, lock_i};
endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL power-up/lock/recovery sequencer on the free-running reference clock.
// PLL_SEQ_RETRY_EN enables retry counting before FAULT; otherwise the first timeout faults.
module pll_lock_seq
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES   = 1000,
   parameter int LOCK_STABLE  = 1024,
   parameter int LOCK_TIMEOUT = 500000,
   parameter int MAX_RETRY    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               pll_lock,
   output logic               pll_pwd,
   output logic               pll_reset,
   output logic               rst_out,
   output logic               locked,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt
);
`ifdef PLL_SEQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif
   localparam int CYC_MAX = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CW = $clog2(CYC_MAX) + 1;
   localparam int SW = $clog2(LOCK_STABLE) + 1;
   state_t             state_q, state_d;
   logic [CW-1:0]      cyc_q, cyc_d;
   logic [SW-1:0]      stable_q, stable_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [RETRY_W:0]   retry_inc;
   outs_t              out_q;
   logic               lock_s;
   pll_lock_sync u_sync (.clk(clk), .rst(rst), .lock_i(pll_lock), .lock_s_o(lock_s));
   assign retry_inc = {1'b0, retry_q} + (RETRY_W+1)'(1);
   always_comb begin
      state_d  = state_q;
      cyc_d    = '0;
      stable_d = '0;
      retry_d  = retry_q;
      if (!enable) begin
         state_d = OFF;
         retry_d = '0;
      end else begin
         case (state_q)
            OFF: state_d = RESET;
            RESET: begin
               cyc_d = cyc_q + CW'(1);
               if (cyc_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               cyc_d    = cyc_q + CW'(1);
               stable_d = lock_s ? stable_q + SW'(1) : '0;
               // stable lock is tested first so it wins a same-cycle timeout
               if (stable_q == SW'(LOCK_STABLE)) begin
                  state_d = RUN;
                  retry_d = '0;
               end else if (cyc_q == CW'(LOCK_TIMEOUT)) begin
                  retry_d = !RETRY_EN ? '0 : retry_inc[RETRY_W] ? '1 : retry_inc[RETRY_W-1:0];
                  state_d = (!RETRY_EN || int'(retry_inc) > MAX_RETRY) ? FAULT : RESET;
               end
            end
            RUN: state_d = lock_s ? RUN : RESET;
            FAULT: state_d = FAULT;
            default: state_d = OFF;
         endcase
      end
      if (state_d != state_q) begin
         cyc_d    = '0;
         stable_d = '0;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= OFF;
         cyc_q    <= '0;
         stable_q <= '0;
         retry_q  <= '0;
         out_q    <= decode(OFF);
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         stable_q <= stable_d;
         retry_q  <= retry_d;
         out_q    <= decode(state_d);
      end
   assign {pll_pwd, pll_reset, rst_out, locked, fault} = out_q;
   assign retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed bring-up, glitch, lock-loss, timeout, async-reset and tie-break checks
module tb_pll_lock_seq;
   localparam logic [4:0] O_OFF  = 5'b11100;
   localparam logic [4:0] O_RST  = 5'b01100;
   localparam logic [4:0] O_WAIT = 5'b00100;
   localparam logic [4:0] O_RUN  = 5'b00010;
   localparam logic [4:0] O_FLT  = 5'b11101;
`ifdef PLL_SEQ_RETRY_EN
   localparam logic [1:0] R_FINAL = 2'd3;
`else
   localparam logic [1:0] R_FINAL = 2'd0;
`endif
   logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, pll_lock = 1'b0;
   logic       pll_pwd, pll_reset, rst_out, locked, fault;
   logic [1:0] retry_cnt;
   logic [4:0] outs;
   int         tests = 0, fails = 0;
   pll_lock_seq #(.RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(64), .MAX_RETRY(2)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pll_lock(pll_lock),
      .pll_pwd(pll_pwd), .pll_reset(pll_reset), .rst_out(rst_out),
      .locked(locked), .fault(fault), .retry_cnt(retry_cnt)
   );
   assign outs = {pll_pwd, pll_reset, rst_out, locked, fault};
   always #5 clk = ~clk;
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [4:0] eo, input logic [1:0] er);
      tests++;
      assert ({outs, retry_cnt} === {eo, er})
      else begin
         fails++;
         $error("FAIL %s: pwd/prst/rst_out/locked/fault=%b retry=%0d, expected %b retry=%0d",
                tag, outs, retry_cnt, eo, er);
      end
   endtask
   initial begin
      tick(2);  check("reset_values", O_OFF, 2'd0);
      rst = 1'b0;
      tick(2);  check("off_idle", O_OFF, 2'd0);
      enable = 1'b1;
      tick(1);  check("bringup_reset", O_RST, 2'd0);
      tick(3);  check("prst_hold", O_RST, 2'd0);
      tick(1);  check("prst_fall", O_WAIT, 2'd0);
      tick(10); pll_lock = 1'b1;
      tick(10); check("lock_pre", O_WAIT, 2'd0);
      tick(1);  check("lock_run", O_RUN, 2'd0);
      pll_lock = 1'b0;
      tick(2);  check("loss_pre", O_RUN, 2'd0);
      tick(1);  check("loss_reset", O_RST, 2'd0);
      tick(3);  check("loss_hold", O_RST, 2'd0);
      tick(1);  check("loss_wait", O_WAIT, 2'd0);
      pll_lock = 1'b1;
      tick(5);  pll_lock = 1'b0;
      tick(1);  pll_lock = 1'b1;
      tick(6);  check("glitch_restart", O_WAIT, 2'd0);
      tick(4);  check("glitch_pre", O_WAIT, 2'd0);
      tick(1);  check("glitch_run", O_RUN, 2'd0);
      pll_lock = 1'b0;
      tick(3);  check("to_loss", O_RST, 2'd0);
      tick(4);  check("to_wait", O_WAIT, 2'd0);
`ifdef PLL_SEQ_RETRY_EN
      for (int k = 1; k <= 3; k++) begin
         tick(64); check("to_waiting", O_WAIT, 2'(k - 1));
         tick(1);  check("to_expire", (k == 3) ? O_FLT : O_RST, 2'(k));
         if (k < 3) begin
            tick(4); check("to_rewait", O_WAIT, 2'(k));
         end
      end
`else
      tick(64); check("to_waiting", O_WAIT, 2'd0);
      tick(1);  check("to_fault", O_FLT, 2'd0);
`endif
      tick(5);  check("fault_hold", O_FLT, R_FINAL);
      enable = 1'b0;
      tick(1);  check("fault_off", O_OFF, 2'd0);
      enable = 1'b1;
      tick(1);  check("restart", O_RST, 2'd0);
      tick(4);  check("restart_wait", O_WAIT, 2'd0);
      tick(3);
      #3 rst = 1'b1;
      #1 check("async_rst", O_OFF, 2'd0);
      #1 rst = 1'b0;
      check("rst_release", O_OFF, 2'd0);
      tick(1);  check("rst_exit", O_RST, 2'd0);
      tick(4);  check("tie_wait", O_WAIT, 2'd0);
      tick(54); pll_lock = 1'b1;
      tick(10); check("tie_pre", O_WAIT, 2'd0);
      tick(1);  check("tie_run", O_RUN, 2'd0);
      enable = 1'b0;
      tick(1);  check("disable", O_OFF, 2'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
